// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths and the control bundle of the ID->EXE slot.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_stage_reg_pkg;

    localparam int ADDRESS_LEN = 32;
    localparam int EXE_CMD_W   = 4;
    localparam int REG_IDX_W   = 4;
    localparam int SHIFT_OP_W  = 12;
    localparam int SIMM_W      = 24;
    localparam int STATUS_W    = 4;

    // Control bits that downstream stages trust to be zero whenever valid is zero
    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// One instruction slot crossing the ID->EXE boundary (decoded control, operands, PC, flags).
// Latency: n/a (wiring only).
// Backpressure: none in the bundle; stalls are signalled beside it via freeze.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = id_ex_stage_reg_pkg::ADDRESS_LEN
);
    import id_ex_stage_reg_pkg::*;

    logic                  valid;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  b;
    logic                  s;
    logic [EXE_CMD_W-1:0]  exe_cmd;
    logic                  imm;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val_rn;
    logic [DATA_W-1:0]     val_rm;
    logic [SHIFT_OP_W-1:0] shift_op;
    logic [SIMM_W-1:0]     simm24;
    logic [REG_IDX_W-1:0]  dest;
    logic [REG_IDX_W-1:0]  src1;
    logic [REG_IDX_W-1:0]  src2;
    logic [STATUS_W-1:0]   status;

    // Producer side of the slot
    modport master (
        output valid, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, imm, pc,
               val_rn, val_rm, shift_op, simm24, dest, src1, src2, status
    );

    // Consumer side of the slot
    modport slave (
        input  valid, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, imm, pc,
               val_rn, val_rm, shift_op, simm24, dest, src1, src2, status
    );

endinterface

// File: rtl/id_ex_stage_reg_pipe_field.sv
// Generic W-bit pipeline field: loads d_i when en_i, or zero when en_i and clr_i together.
// Latency: 1 cycle.
// Backpressure: en_i low holds the field; clr_i has no effect while held.
module pipe_field #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] field_q;
    logic [W-1:0] field_d;

    // Next value: zero on clear, otherwise the incoming field
    always_comb begin
        field_d = clr_i ? '0 : d_i;
    end

    // Field register, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_q <= '0;
        end else if (en_i) begin
            field_q <= field_d;
        end
    end

    assign q_o = field_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EXE pipeline register with flush (bubble insert) and freeze (hold), plus a saturating bubble counter.
// Latency: 1 cycle, no combinational path from ID inputs to EXE outputs.
// Backpressure: freeze holds every output and the counter; flush overrides freeze and loads a bubble.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = ADDRESS_LEN,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 freeze,
    id_ex_stage_reg_if.slave     id_i,
    id_ex_stage_reg_if.master    exe_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    localparam int DATA_BITS = EXE_CMD_W + 1 + 3 * DATA_W + SHIFT_OP_W + SIMM_W
                             + 3 * REG_IDX_W + STATUS_W;

    ctrl_t                ctrl_d;
    ctrl_t                ctrl_q;
    logic [DATA_BITS-1:0] data_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 load_en;
    logic                 ctrl_clr;
    logic                 bubble_load;
    logic [CNT_W-1:0]     bubble_cnt_d;
    logic [CNT_W-1:0]     bubble_cnt_q;

    // Flush must win over freeze, so it also forces the load enable
    assign load_en     = ~freeze | flush;
    // A hazard bubble (valid low) zeroes control exactly like a flush, keeping valid=0 => no side effects
    assign ctrl_clr    = flush | ~id_i.valid;
    assign bubble_load = flush | (~freeze & ~id_i.valid);

    // Gather the control bits of the incoming slot
    always_comb begin
        ctrl_d          = '0;
        ctrl_d.valid    = id_i.valid;
        ctrl_d.wb_en    = id_i.wb_en;
        ctrl_d.mem_r_en = id_i.mem_r_en;
        ctrl_d.mem_w_en = id_i.mem_w_en;
        ctrl_d.b        = id_i.b;
        ctrl_d.s        = id_i.s;
    end

    assign data_d = {id_i.exe_cmd, id_i.imm, id_i.pc, id_i.val_rn, id_i.val_rm, id_i.shift_op,
                     id_i.simm24, id_i.dest, id_i.src1, id_i.src2, id_i.status};

    pipe_field #(.W(CTRL_W)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ctrl_clr),
        .en_i  (load_en),
        .d_i   (ctrl_d),
        .q_o   (ctrl_q)
    );

    // Data is kept on a valid-low load (don't-care downstream) but zeroed on flush
    pipe_field #(.W(DATA_BITS)) u_data (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (load_en),
        .d_i   (data_d),
        .q_o   (data_q)
    );

    assign exe_o.valid    = ctrl_q.valid;
    assign exe_o.wb_en    = ctrl_q.wb_en;
    assign exe_o.mem_r_en = ctrl_q.mem_r_en;
    assign exe_o.mem_w_en = ctrl_q.mem_w_en;
    assign exe_o.b        = ctrl_q.b;
    assign exe_o.s        = ctrl_q.s;
    assign {exe_o.exe_cmd, exe_o.imm, exe_o.pc, exe_o.val_rn, exe_o.val_rm, exe_o.shift_op,
            exe_o.simm24, exe_o.dest, exe_o.src1, exe_o.src2, exe_o.status} = data_q;

    // Bubble count saturates at all-ones rather than wrapping
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       freeze;
    logic [3:0] bubble_cnt;

    int checks;
    int errors;

    id_ex_stage_reg_if #(.DATA_W(32)) id_bus ();
    id_ex_stage_reg_if #(.DATA_W(32)) exe_bus ();

    id_ex_stage_reg #(.DATA_W(32), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .freeze       (freeze),
        .id_i         (id_bus),
        .exe_o        (exe_bus),
        .bubble_cnt_o (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_slot(input logic valid, input logic wb_en, input logic mem_w_en,
                              input logic [3:0] cmd, input logic [31:0] pc,
                              input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] dest);
        id_bus.valid    = valid;
        id_bus.wb_en    = wb_en;
        id_bus.mem_r_en = 1'b0;
        id_bus.mem_w_en = mem_w_en;
        id_bus.b        = 1'b0;
        id_bus.s        = 1'b0;
        id_bus.exe_cmd  = cmd;
        id_bus.imm      = 1'b1;
        id_bus.pc       = pc;
        id_bus.val_rn   = rn;
        id_bus.val_rm   = rm;
        id_bus.shift_op = 12'hA5C;
        id_bus.simm24   = 24'h80_0001;
        id_bus.dest     = dest;
        id_bus.src1     = 4'd7;
        id_bus.src2     = 4'd9;
        id_bus.status   = 4'b1010;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (exe_bus.valid !== 1'b0 || exe_bus.wb_en !== 1'b0 || exe_bus.pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b wb_en=%0b pc=%h, required 0", exe_bus.valid, exe_bus.wb_en, exe_bus.pc);
        end
        checks++;
        if (bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d required 0", bubble_cnt);
        end
        tick();
        checks++;
        if (exe_bus.valid !== 1'b0 || exe_bus.val_rn !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: valid=%0b val_rn=%h required 0", exe_bus.valid, exe_bus.val_rn);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        drive_slot(1'b1, 1'b1, 1'b0, 4'b0010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1234_5678, 4'd3);
        tick();
        checks++;
        if (exe_bus.valid !== 1'b1 || exe_bus.wb_en !== 1'b1 || exe_bus.mem_w_en !== 1'b0) begin
            errors++;
            $display("FAIL load_ctrl: valid=%0b wb_en=%0b mem_w_en=%0b required 1 1 0",
                     exe_bus.valid, exe_bus.wb_en, exe_bus.mem_w_en);
        end
        checks++;
        if (exe_bus.pc !== 32'h0000_0010 || exe_bus.val_rn !== 32'hDEAD_BEEF || exe_bus.val_rm !== 32'h1234_5678) begin
            errors++;
            $display("FAIL load_data: pc=%h rn=%h rm=%h required 00000010 deadbeef 12345678",
                     exe_bus.pc, exe_bus.val_rn, exe_bus.val_rm);
        end
        checks++;
        if (exe_bus.exe_cmd !== 4'b0010 || exe_bus.dest !== 4'd3 || exe_bus.imm !== 1'b1) begin
            errors++;
            $display("FAIL load_fields: cmd=%b dest=%0d imm=%0b required 0010 3 1",
                     exe_bus.exe_cmd, exe_bus.dest, exe_bus.imm);
        end
        checks++;
        if (exe_bus.shift_op !== 12'hA5C || exe_bus.simm24 !== 24'h80_0001 || exe_bus.src1 !== 4'd7
            || exe_bus.src2 !== 4'd9 || exe_bus.status !== 4'b1010) begin
            errors++;
            $display("FAIL load_misc: shift=%h simm=%h src1=%0d src2=%0d nzcv=%b required a5c 800001 7 9 1010",
                     exe_bus.shift_op, exe_bus.simm24, exe_bus.src1, exe_bus.src2, exe_bus.status);
        end
        checks++;
        if (bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL load_cnt: got %0d required 0", bubble_cnt);
        end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_slot(1'b1, 1'b0, 1'b1, 4'(i + 5), 32'h100 + 32'(i), 32'hCAFE_0000 + 32'(i), 32'h0, 4'(i + 10));
            tick();
            checks++;
            if (exe_bus.pc !== 32'h0000_0010 || exe_bus.val_rn !== 32'hDEAD_BEEF || exe_bus.wb_en !== 1'b1
                || exe_bus.mem_w_en !== 1'b0 || exe_bus.dest !== 4'd3) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: pc=%h rn=%h wb_en=%0b mem_w=%0b dest=%0d required 10 deadbeef 1 0 3",
                         i, exe_bus.pc, exe_bus.val_rn, exe_bus.wb_en, exe_bus.mem_w_en, exe_bus.dest);
            end
        end
        // A valid-low slot under freeze must not count as a bubble
        id_bus.valid = 1'b0;
        tick();
        checks++;
        if (bubble_cnt !== 4'd0 || exe_bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL freeze_no_bubble: cnt=%0d valid=%0b required 0 1", bubble_cnt, exe_bus.valid);
        end
        freeze = 1'b0;
        drive_slot(1'b1, 1'b0, 1'b1, 4'b1001, 32'h0000_0200, 32'h0BAD_F00D, 32'h0, 4'd12);
        tick();
        checks++;
        if (exe_bus.pc !== 32'h0000_0200 || exe_bus.val_rn !== 32'h0BAD_F00D || exe_bus.mem_w_en !== 1'b1
            || exe_bus.wb_en !== 1'b0 || exe_bus.exe_cmd !== 4'b1001) begin
            errors++;
            $display("FAIL freeze_release: pc=%h rn=%h mem_w=%0b wb=%0b cmd=%b required 200 0badf00d 1 0 1001",
                     exe_bus.pc, exe_bus.val_rn, exe_bus.mem_w_en, exe_bus.wb_en, exe_bus.exe_cmd);
        end
    endtask

    task automatic test_flush_freeze();
        drive_slot(1'b1, 1'b1, 1'b0, 4'b0110, 32'h0000_0300, 32'h7777_7777, 32'h8888_8888, 4'd5);
        flush  = 1'b1;
        freeze = 1'b1;
        tick();
        flush  = 1'b0;
        freeze = 1'b0;
        checks++;
        if (exe_bus.valid !== 1'b0 || exe_bus.wb_en !== 1'b0 || exe_bus.mem_w_en !== 1'b0
            || exe_bus.mem_r_en !== 1'b0 || exe_bus.b !== 1'b0 || exe_bus.s !== 1'b0) begin
            errors++;
            $display("FAIL flush_ctrl: valid=%0b wb=%0b mr=%0b mw=%0b b=%0b s=%0b required all 0",
                     exe_bus.valid, exe_bus.wb_en, exe_bus.mem_r_en, exe_bus.mem_w_en, exe_bus.b, exe_bus.s);
        end
        checks++;
        if (exe_bus.val_rn !== 32'h0 || exe_bus.pc !== 32'h0 || exe_bus.dest !== 4'd0) begin
            errors++;
            $display("FAIL flush_data: rn=%h pc=%h dest=%0d required 0", exe_bus.val_rn, exe_bus.pc, exe_bus.dest);
        end
        checks++;
        if (bubble_cnt !== 4'd1) begin
            errors++;
            $display("FAIL flush_cnt: got %0d required 1", bubble_cnt);
        end
    endtask

    task automatic test_bubble();
        drive_slot(1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_0400, 32'h1111_2222, 32'h0000_0055, 4'd8);
        tick();
        checks++;
        if (exe_bus.mem_w_en !== 1'b0 || exe_bus.valid !== 1'b0 || exe_bus.wb_en !== 1'b0) begin
            errors++;
            $display("FAIL bubble_ctrl: mw=%0b valid=%0b wb=%0b required 0 0 0",
                     exe_bus.mem_w_en, exe_bus.valid, exe_bus.wb_en);
        end
        checks++;
        if (exe_bus.val_rm !== 32'h0000_0055 || exe_bus.pc !== 32'h0000_0400) begin
            errors++;
            $display("FAIL bubble_data: rm=%h pc=%h required 00000055 00000400", exe_bus.val_rm, exe_bus.pc);
        end
        checks++;
        if (bubble_cnt !== 4'd2) begin
            errors++;
            $display("FAIL bubble_cnt: got %0d required 2", bubble_cnt);
        end
    endtask

    task automatic test_saturate();
        int expected;
        expected = 2;
        for (int i = 0; i < 20; i++) begin
            if ((i % 2) == 0) begin
                flush = 1'b1;
                id_bus.valid = 1'b1;
            end else begin
                flush = 1'b0;
                id_bus.valid = 1'b0;
            end
            tick();
            if (expected < 15) expected++;
            checks++;
            if (bubble_cnt !== 4'(expected)) begin
                errors++;
                $display("FAIL saturate[%0d]: got %0d required %0d", i, bubble_cnt, expected);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_mid_reset();
        id_bus.valid    = 1'b1;
        id_bus.wb_en    = 1'b1;
        id_bus.mem_r_en = 1'b1;
        id_bus.mem_w_en = 1'b1;
        id_bus.b        = 1'b1;
        id_bus.s        = 1'b1;
        id_bus.exe_cmd  = '1;
        id_bus.imm      = 1'b1;
        id_bus.pc       = '1;
        id_bus.val_rn   = '1;
        id_bus.val_rm   = '1;
        id_bus.shift_op = '1;
        id_bus.simm24   = '1;
        id_bus.dest     = '1;
        id_bus.src1     = '1;
        id_bus.src2     = '1;
        id_bus.status   = '1;
        tick();
        checks++;
        if (exe_bus.valid !== 1'b1 || exe_bus.pc !== 32'hFFFF_FFFF || bubble_cnt !== 4'd15) begin
            errors++;
            $display("FAIL ones_load: valid=%0b pc=%h cnt=%0d required 1 ffffffff 15",
                     exe_bus.valid, exe_bus.pc, bubble_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (exe_bus.valid !== 1'b0 || exe_bus.wb_en !== 1'b0 || exe_bus.s !== 1'b0 || exe_bus.pc !== 32'h0
            || exe_bus.val_rm !== 32'h0 || exe_bus.status !== 4'h0 || bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b wb=%0b s=%0b pc=%h rm=%h nzcv=%b cnt=%0d required all 0",
                     exe_bus.valid, exe_bus.wb_en, exe_bus.s, exe_bus.pc, exe_bus.val_rm, exe_bus.status, bubble_cnt);
        end
        tick();
        checks++;
        if (exe_bus.valid !== 1'b0 || exe_bus.val_rn !== 32'h0 || bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_held: valid=%0b rn=%h cnt=%0d required 0", exe_bus.valid, exe_bus.val_rn, bubble_cnt);
        end
        rst = 1'b0;
        drive_slot(1'b1, 1'b1, 1'b0, 4'b0100, 32'h0000_0014, 32'h0000_00AB, 32'h0, 4'd1);
        tick();
        checks++;
        if (exe_bus.valid !== 1'b1 || exe_bus.pc !== 32'h0000_0014 || exe_bus.val_rn !== 32'h0000_00AB
            || bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_load: valid=%0b pc=%h rn=%h cnt=%0d required 1 14 ab 0",
                     exe_bus.valid, exe_bus.pc, exe_bus.val_rn, bubble_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        freeze = 1'b0;
        drive_slot(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 4'd0);
        test_reset();
        test_load();
        test_freeze();
        test_flush_freeze();
        test_bubble();
        test_saturate();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
